bus_size_sequencer: RTL
=======================

// Module: bus_size_sequencer
// PURPOSE
//  Sequences one 68030-style CPU access (A[1:0], SIZ[1:0]) onto a 16-bit target port.
//  Splits a long, 3-byte or misaligned word access into one or two halfword cycles with byte enables.
//  Runs each cycle as a REQ/ACK handshake and reassembles read data into 32-bit big-endian lanes.
//  Sits between the CPU bus-cycle front end and 16-bit peripherals/ROM.
// PARAMETERS
//  TIMEOUT  255  port cycles without P_ACK/P_ERR before abort; 8-bit counter, legal range 1..255
// PORTS
//  CLK      in   1   sole clock; all state changes on rising edge
//  RST      in   1   asynchronous, active-high reset
//  REQ      in   1   CPU access request; held until ACK or BERR
//  WR       in   1   1=write, 0=read; stable while REQ high
//  A        in   2   CPU address bits 1:0; stable while REQ high
//  SIZ      in   2   01=byte, 10=word, 11=3-byte, 00=long; stable while REQ high
//  WDATA    in   32  CPU write data, big-endian: byte0=[31:24] .. byte3=[7:0]
//  RDATA    out  32  assembled read data; valid in the ACK cycle
//  ACK      out  1   one-cycle pulse: access complete
//  BERR     out  1   one-cycle pulse: access aborted (port error or timeout)
//  P_REQ    out  1   port cycle request
//  P_WR     out  1   port direction
//  P_A1     out  1   halfword select: 0=bytes 0/1, 1=bytes 2/3
//  P_BE     out  2   P_BE[1]=even/upper byte [15:8], P_BE[0]=odd/lower byte [7:0]
//  P_WDATA  out  16  halfword write data
//  P_RDATA  in   16  halfword read data; sampled on the edge where P_ACK=1
//  P_ACK    in   1   port cycle complete
//  P_ERR    in   1   port cycle error; takes priority over P_ACK on the same edge
// BEHAVIOUR
//  Reset: all outputs 0; RDATA=0; state IDLE; timeout counter 0. Reset mid-access drops P_REQ at once; no ACK/BERR.
//  Byte mask M[3:0], bit 3=byte0: n = (SIZ==00)?4:SIZ; bytes A..min(A+n-1,3) set, bytes past 3 dropped.
//   Same lane rule as the CPU decode: A=01 SIZ=00 -> 0111; A=11 any SIZ -> 0001.
//  Cycle LO is needed if M[3:2]!=0: P_A1=0, P_BE=M[3:2], P_WDATA=WDATA[31:16].
//  Cycle HI is needed if M[1:0]!=0: P_A1=1, P_BE=M[1:0], P_WDATA=WDATA[15:0]. LO always runs first.
//  FSM states:
//   IDLE: on REQ=1, latch A/SIZ/WR/M; clear RDATA; go to LO if needed, else HI. P_REQ=1 from next cycle.
//   LO/HI: P_REQ=1, P_WR/P_A1/P_BE/P_WDATA constant.
//    P_ERR=1 -> BERR pulse, P_REQ=0 -> WAITREL.
//    P_ACK=1 -> capture P_RDATA into its half of RDATA (reads only), P_REQ=0.
//      LO with HI needed -> GAP, else -> DONE.
//    Counter reaches TIMEOUT -> BERR pulse -> WAITREL.
//   GAP: one cycle with P_REQ=0 (port sees REQ drop between cycles) -> HI.
//   DONE: ACK=1 for exactly one cycle -> WAITREL.
//   WAITREL: wait for REQ=0, then IDLE. A held-high REQ never starts a second access.
//  Timeout counter: cleared on entry to LO/HI; +1 each cycle in LO/HI without P_ACK/P_ERR.
//  Latency with zero-wait port (P_ACK in first P_REQ cycle):
//   one-half access: REQ at edge k -> ACK high after edge k+2.
//   two-half access: ACK high after edge k+4.
//  RDATA: halves not transferred read 0; it holds its value after ACK until the next accepted REQ.
//  REQ dropped by the CPU mid-access: ignored; the sequence completes (port cycles are not abandoned).
//  ACK and BERR are never high together; at most one of them per accepted REQ.
// TESTING
//  1. Read long, A=00 SIZ=00; port returns 1234 then 5678 -> LO(BE=11), GAP, HI(BE=11); RDATA=12345678; one ACK.
//  2. Write byte, A=11 SIZ=01, WDATA=000000AB -> single HI cycle, P_BE=01, P_WDATA=00AB; ACK after edge k+2.
//  3. Write long, A=01 SIZ=00, WDATA=11223344 -> LO BE=01 P_WDATA=1122, then HI BE=11 P_WDATA=3344.
//  4. TIMEOUT=4, no P_ACK -> P_REQ high 4 cycles, then BERR pulse, no ACK; next access still works.
//  5. P_ERR with P_ACK on LO of a long read -> BERR only, HI never issued.
//  6. RST asserted mid-HI -> outputs 0 immediately; REQ held high after release starts a fresh access.

Source files
------------

// File: rtl/bus_size_sequencer.sv
// -----------------------------------------------------------------------------
// bus_size_sequencer
//
// Purpose:
//   Takes one 68030-style CPU access (A[1:0], SIZ[1:0]) and runs it on a
//   16-bit target port. The access becomes one or two halfword cycles with
//   byte enables. Each port cycle is a REQ/ACK handshake. Read data is
//   reassembled into 32-bit big-endian lanes (byte0 = [31:24]).
//
// Handshake semantics:
//   CPU side : REQ is held high until ACK or BERR pulses for one cycle.
//              An access is accepted only from IDLE. After completion the
//              block waits for REQ to go low before it accepts another one.
//   Port side: P_REQ is high for the whole port cycle. P_WR, P_A1, P_BE and
//              P_WDATA are constant while P_REQ is high. A cycle ends on the
//              first rising edge that sees P_ACK or P_ERR. P_ERR wins over
//              P_ACK when both are high.
//
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   REQ, WR, A, SIZ, WDATA   CPU access request and attributes
//   RDATA, ACK, BERR      assembled read data, completion/abort pulses
//   P_REQ, P_WR, P_A1, P_BE, P_WDATA   port cycle outputs
//   P_RDATA, P_ACK, P_ERR port cycle responses
//   DBG_STATE             current FSM state
//
// Parameters:
//   TIMEOUT  number of port cycles with no P_ACK/P_ERR before the access is
//            aborted (1..255)
// -----------------------------------------------------------------------------
module bus_size_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        WR,
    input  logic [1:0]  A,
    input  logic [1:0]  SIZ,
    input  logic [31:0] WDATA,
    output logic [31:0] RDATA,
    output logic        ACK,
    output logic        BERR,
    output logic        P_REQ,
    output logic        P_WR,
    output logic        P_A1,
    output logic [1:0]  P_BE,
    output logic [15:0] P_WDATA,
    input  logic [15:0] P_RDATA,
    input  logic        P_ACK,
    input  logic        P_ERR,
    output logic [2:0]  DBG_STATE
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LO      = 3'd1,
        S_HI      = 3'd2,
        S_GAP     = 3'd3,
        S_DONE    = 3'd4,
        S_WAITREL = 3'd5
    } state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t      r_state;
    state_t      w_next;
    logic        r_wr;
    logic [3:0]  r_mask;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [7:0]  r_cnt;
    logic        r_ack;
    logic        r_berr;

    logic [2:0]  w_n;
    logic [2:0]  w_last;
    logic [3:0]  w_mask;
    logic        w_in_port;
    logic        w_tmo;
    logic        w_ack_set;
    logic        w_berr_set;

    // Byte mask for the incoming request. Bit 3 is byte0. Bytes from A up to
    // A+n-1 are set, and anything past byte 3 is dropped. w_last can reach 6,
    // which still fits in 3 bits.
    always_comb begin
        w_n       = (SIZ == 2'b00) ? 3'd4 : {1'b0, SIZ};
        w_last    = {1'b0, A} + w_n - 3'd1;
        w_mask[3] = (A == 2'd0);
        w_mask[2] = (A <= 2'd1) && (w_last >= 3'd1);
        w_mask[1] = (A <= 2'd2) && (w_last >= 3'd2);
        w_mask[0] = (w_last >= 3'd3);
    end

    assign w_in_port = (r_state == S_LO) || (r_state == S_HI);
    // This cycle is the TIMEOUT-th consecutive port cycle with no response.
    assign w_tmo     = ((r_cnt + 8'd1) == TMO);

    always_comb begin
        w_next     = r_state;
        w_ack_set  = 1'b0;
        w_berr_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (REQ) begin
                    w_next = (w_mask[3:2] != 2'b00) ? S_LO : S_HI;
                end
            end
            S_LO, S_HI: begin
                if (P_ERR) begin
                    w_berr_set = 1'b1;
                    w_next     = S_WAITREL;
                end else if (P_ACK) begin
                    if ((r_state == S_LO) && (r_mask[1:0] != 2'b00)) begin
                        w_next = S_GAP;
                    end else begin
                        w_next = S_DONE;
                    end
                end else if (w_tmo) begin
                    w_berr_set = 1'b1;
                    w_next     = S_WAITREL;
                end
            end
            S_GAP: begin
                w_next = S_HI;
            end
            S_DONE: begin
                w_ack_set = 1'b1;
                w_next    = S_WAITREL;
            end
            S_WAITREL: begin
                if (!REQ) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_wr    <= 1'b0;
            r_mask  <= 4'b0000;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_cnt   <= 8'd0;
            r_ack   <= 1'b0;
            r_berr  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ack   <= w_ack_set;
            r_berr  <= w_berr_set;

            if ((r_state == S_IDLE) && REQ) begin
                r_wr    <= WR;
                r_mask  <= w_mask;
                r_wdata <= WDATA;
                r_rdata <= 32'd0;
            end

            if (w_in_port && P_ACK && !P_ERR && !r_wr) begin
                if (r_state == S_HI) begin
                    r_rdata[15:0]  <= P_RDATA;
                end else begin
                    r_rdata[31:16] <= P_RDATA;
                end
            end

            // Count only while waiting inside one port cycle. This also
            // clears the counter on every entry to LO/HI.
            if (w_in_port && (w_next == r_state)) begin
                r_cnt <= r_cnt + 8'd1;
            end else begin
                r_cnt <= 8'd0;
            end
        end
    end

    // Port outputs are driven only inside a port cycle and are 0 otherwise.
    assign P_REQ     = w_in_port;
    assign P_WR      = w_in_port & r_wr;
    assign P_A1      = (r_state == S_HI);
    assign P_BE      = (r_state == S_LO) ? r_mask[3:2] :
                       (r_state == S_HI) ? r_mask[1:0] : 2'b00;
    assign P_WDATA   = (r_state == S_LO) ? r_wdata[31:16] :
                       (r_state == S_HI) ? r_wdata[15:0]  : 16'd0;

    assign RDATA     = r_rdata;
    assign ACK       = r_ack;
    assign BERR      = r_berr;
    assign DBG_STATE = r_state;

endmodule
